bus_trace_buffer: RTL
=====================

// Module: bus_trace_buffer
// PURPOSE
//  Synthesisable on-chip logic analyser for the cpu data bus, replacing console-only bus printing.
//  Captures a timestamped sample each time the snooped bus changes into a DEPTH-entry circular buffer.
//  Supports a masked value trigger and a programmable post-trigger sample count.
//  Captured trace is unloaded oldest-first over a valid/ready read port.
// PARAMETERS
//  DATA_W  8   width of snooped bus
//  DEPTH   16  trace entries; power of 2, >=2
//  TS_W    16  timestamp counter width
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       synchronous, active-low reset
//  bus          in   DATA_W  snooped bus value
//  arm          in   1       start capture (accepted only in IDLE)
//  force_trig   in   1       unconditional trigger (ARMED only)
//  trig_value   in   DATA_W  trigger compare value
//  trig_mask    in   DATA_W  1 = bit participates in compare; all-0 = trigger on first sample
//  post_count   in   log2(DEPTH)  samples captured after the trigger sample (max DEPTH-1)
//  rd_valid     out  1       rd_data/rd_ts hold the oldest unread entry
//  rd_ready     in   1       consumer accepts entry when rd_valid&rd_ready
//  rd_data      out  DATA_W  captured bus value
//  rd_ts        out  TS_W    timestamp of capture
//  state        out  2       0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  triggered    out  1       sticky; trigger occurred this capture
//  overflow     out  1       sticky; pre-trigger data overwritten
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, ts=0, wptr=0, count=0, prev_bus=0.
//   triggered=0, overflow=0, rd_valid=0; rd_data/rd_ts=0. Applies mid-capture/mid-readout; buffer contents are don't-care.
//  ts: free-running, +1 every cycle out of reset, wraps 2^TS_W-1 -> 0.
//  prev_bus <= bus every cycle.
//  Sample event (ARMED/POST only): bus != prev_bus, OR first cycle in ARMED (always captured).
//   Action: mem[wptr] <= {ts,bus}; wptr <= wptr+1 mod DEPTH; count <= min(count+1,DEPTH).
//  Overflow: set if a sample event occurs in ARMED with count==DEPTH (oldest overwritten).
//  IDLE: arm=1 -> ARMED next cycle; count, triggered, overflow cleared.
//   Buffer from the previous capture is discarded.
//  ARMED: trigger = sample event & (((bus^trig_value)&trig_mask)==0), or force_trig.
//   force_trig on a cycle without a sample event also writes the current bus.
//   On trigger: entry written, triggered<=1, rem<=post_count.
//   Next state is POST, or DONE if post_count==0.
//  POST: each sample event writes, rem<=rem-1; rem==1 at write -> DONE next cycle.
//   force_trig/trigger ignored. post_count<=DEPTH-1 guarantees the trigger entry survives.
//   count saturates; overflow not set in POST.
//  DONE: no capture. rd_ptr = wptr-count mod DEPTH.
//   rd_valid = (count!=0); rd_data/rd_ts = mem[rd_ptr] combinationally.
//   Handshake: rd_valid&rd_ready -> count<=count-1 (oldest popped). rd_data stable while rd_valid&!rd_ready.
//   count reaches 0 -> IDLE next cycle; arm ignored in DONE.
//  arm ignored outside IDLE; inputs trig_value/mask/post_count are sampled live (hold stable while armed).
//  Latency: a bus change at edge N is captured with ts of cycle N (the compare uses the registered prev_bus).
// TESTING
//  Arm, bus 00->11->22, mask=FF val=22, post=0: DONE; read 3 entries: 00,11,22; ts strictly increasing; triggered=1.
//  Arm, 20 distinct values 01..14, val=14, post=0: overflow=1, count=16, read 05..14 in order.
//  Trigger on 0x40 with post=3, then bus 41,42,43,44: entries end 40,41,42,43; 44 not captured; state=DONE.
//  Bus held constant 0x55, force_trig after 10 cycles, post=0: exactly 2 entries (55 @arm, 55 @force).
//  Readout with rd_ready toggling 1-0-1: rd_data holds while rd_ready=0; no entry skipped/duplicated; IDLE after last.
//  rst_n=0 mid-POST and mid-readout: next cycle state=0, rd_valid=0, triggered=0, overflow=0, ts=0.

Source files
------------

// File: rtl/bus_trace_buffer_if.sv
// Snoop, trigger-configuration and trace read-port signals of the bus trace buffer.
// The design uses the slave modport. The agent that drives the snooped bus and reads the trace uses the master modport.
interface bus_trace_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] bus;
    logic              arm;
    logic              force_trig;
    logic [DATA_W-1:0] trig_value;
    logic [DATA_W-1:0] trig_mask;
    logic [PTR_W-1:0]  post_count;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_ts;
    logic [1:0]        state;
    logic              triggered;
    logic              overflow;

    modport master (
        output bus, arm, force_trig, trig_value, trig_mask, post_count, rd_ready,
        input  rd_valid, rd_data, rd_ts, state, triggered, overflow
    );

    modport slave (
        input  bus, arm, force_trig, trig_value, trig_mask, post_count, rd_ready,
        output rd_valid, rd_data, rd_ts, state, triggered, overflow
    );
endinterface

// File: rtl/bus_trace_buffer.sv
// On-chip logic analyser. Change-driven timestamped capture goes into a circular buffer.
// Capture uses a masked or forced trigger and a post-trigger sample count. Readout is oldest-first over valid/ready.
module bus_trace_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_trace_buffer_if.slave  dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORD_W = TS_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [TS_W-1:0]   ts_reg;
    logic [DATA_W-1:0] prev_bus_reg;
    logic [PTR_W-1:0]  wptr_reg;
    logic [PTR_W-1:0]  rem_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              first_reg;
    logic              triggered_reg;
    logic              overflow_reg;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              changed;
    logic              sample;
    logic              match;
    logic              trig;
    logic              wr_en;
    logic              full;
    logic              rd_valid;
    logic              pop;
    logic [PTR_W-1:0]  rd_ptr;
    logic [WORD_W-1:0] rd_word;

    // The first ARMED cycle always captures, so the trace starts with the bus value present at arm time.
    assign changed = (dbg.bus != prev_bus_reg);
    assign sample  = ((state_reg == ARMED) && (changed || first_reg)) ||
                     ((state_reg == POST) && changed);
    assign match   = (((dbg.bus ^ dbg.trig_value) & dbg.trig_mask) == '0);
    assign trig    = (state_reg == ARMED) && ((sample && match) || dbg.force_trig);
    assign wr_en   = sample || trig;
    assign full    = (count_reg == CNT_W'(DEPTH));

    // When the buffer is full, the count's low bits are zero, so rd_ptr lands on wptr, which is the oldest entry.
    assign rd_ptr   = wptr_reg - count_reg[PTR_W-1:0];
    assign rd_valid = (state_reg == DONE) && (count_reg != '0);
    assign pop      = rd_valid && dbg.rd_ready;
    assign rd_word  = rd_valid ? mem[rd_ptr] : '0;

    assign dbg.rd_valid  = rd_valid;
    assign dbg.rd_data   = rd_word[DATA_W-1:0];
    assign dbg.rd_ts     = rd_word[WORD_W-1:DATA_W];
    assign dbg.state     = state_reg;
    assign dbg.triggered = triggered_reg;
    assign dbg.overflow  = overflow_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_reg] <= {ts_reg, dbg.bus};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ts_reg        <= '0;
            prev_bus_reg  <= '0;
            wptr_reg      <= '0;
            rem_reg       <= '0;
            count_reg     <= '0;
            first_reg     <= 1'b0;
            triggered_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            ts_reg       <= ts_reg + TS_W'(1);
            prev_bus_reg <= dbg.bus;

            if (wr_en) begin
                wptr_reg <= wptr_reg + PTR_W'(1);
                if (!full) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (dbg.arm) begin
                        state_reg     <= ARMED;
                        count_reg     <= '0;
                        triggered_reg <= 1'b0;
                        overflow_reg  <= 1'b0;
                        first_reg     <= 1'b1;
                    end
                end
                ARMED: begin
                    first_reg <= 1'b0;
                    // A forced write into a full buffer also destroys pre-trigger history.
                    if (wr_en && full) begin
                        overflow_reg <= 1'b1;
                    end
                    if (trig) begin
                        triggered_reg <= 1'b1;
                        rem_reg       <= dbg.post_count;
                        state_reg     <= (dbg.post_count == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (sample) begin
                        rem_reg <= rem_reg - PTR_W'(1);
                        if (rem_reg == PTR_W'(1)) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (pop) begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                    if ((count_reg == '0) || (pop && (count_reg == CNT_W'(1)))) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
